// File: rtl/shift_defs.sv
// Shared encodings for the multi-cycle shifter: ALU shift opcodes and controller states.
package shift_defs;

    localparam int OP_W = 2;
    localparam int ST_W = 2;

    localparam logic [OP_W-1:0] OP_SLL = 2'b00;
    localparam logic [OP_W-1:0] OP_SRL = 2'b01;
    localparam logic [OP_W-1:0] OP_SRA = 2'b11;

    localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [ST_W-1:0] ST_SHIFT = 2'd1;
    localparam logic [ST_W-1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/shift_step.sv
// Combinational one-bit shift of a WIDTH-bit word; the reserved opcode falls back to SLL.
module shift_step
    import shift_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [OP_W-1:0]  op_i,
    output logic [WIDTH-1:0] data_o
);

    always_comb begin
        case (op_i)
            OP_SRL:  data_o = {1'b0, data_i[WIDTH-1:1]};
            OP_SRA:  data_o = {data_i[WIDTH-1], data_i[WIDTH-1:1]};
            default: data_o = {data_i[WIDTH-2:0], 1'b0};
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle SLL/SRL/SRA controller for the EX stage: one bit per cycle, busy_o stalls the pipe,
// done_o pulses once with result_o, which is held in its own register until the next run completes.
module shift_sequencer
    import shift_defs::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               flush_i,
    input  logic [OP_W-1:0]    op_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic [WIDTH-1:0]   data_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [WIDTH-1:0]   result_o
);

    logic [ST_W-1:0]    state_q,  state_d;
    logic [WIDTH-1:0]   work_q,   work_d;
    logic [OP_W-1:0]    op_q,     op_d;
    logic [SHAMT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   stepped;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .data_i (work_q),
        .op_i   (op_q),
        .data_o (stepped)
    );

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start_i) begin
                    work_d = data_i;
                    op_d   = op_i;
                    cnt_d  = shamt_i;
                    // A zero shift completes immediately, so its result is the operand itself.
                    if (shamt_i != '0) begin
                        state_d = ST_SHIFT;
                    end else begin
                        state_d  = ST_DONE;
                        result_d = data_i;
                    end
                end
            end
            ST_SHIFT: begin
                work_d = stepped;
                cnt_d  = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    state_d  = ST_DONE;
                    result_d = stepped;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A flush discards the in-flight operation entirely, including a start in the same cycle.
        if (flush_i) begin
            state_d  = ST_IDLE;
            work_d   = work_q;
            op_d     = op_q;
            cnt_d    = cnt_q;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            work_q   <= '0;
            op_q     <= OP_SLL;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign busy_o   = (state_q == ST_SHIFT);
    assign done_o   = (state_q == ST_DONE);
    assign result_o = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: a queue of expected (cycle, result) pairs is filled at each
// accepted start and drained when the model says done_o must fire; outputs are checked every cycle.
module tb_shift_sequencer;

    typedef struct {
        int          doneCycle;
        logic [31:0] res;
    } expEntry_t;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic        flush_i;
    logic [1:0]  op_i;
    logic [4:0]  shamt_i;
    logic [31:0] data_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;

    int          cycle = 0;
    int          total = 0;
    int          bad   = 0;
    expEntry_t   expQ[$];
    logic [31:0] expResult = 32'h0;
    int          busyFrom  = 1;
    int          busyTo    = 0;

    shift_sequencer #(
        .WIDTH   (32),
        .SHAMT_W (5)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_i),
        .flush_i  (flush_i),
        .op_i     (op_i),
        .shamt_i  (shamt_i),
        .data_i   (data_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [31:0] shiftModel(input logic [1:0] op, input logic [4:0] sh,
                                               input logic [31:0] d);
        case (op)
            2'b01:   return d >> sh;
            2'b11:   return 32'($signed(d) >>> sh);
            default: return d << sh;
        endcase
    endfunction

    // Compares all outputs for the current cycle against the bench model.
    task automatic checkOutput();
        logic expDone;
        logic expBusy;
        expDone = 1'b0;
        if (expQ.size() > 0 && expQ[0].doneCycle == cycle) begin
            expDone   = 1'b1;
            expResult = expQ[0].res;
            void'(expQ.pop_front());
        end
        expBusy = (cycle >= busyFrom) && (cycle <= busyTo);

        total++;
        assert (done_o === expDone) else begin
            bad++;
            $error("FAIL done_o cycle=%0d got=%b exp=%b", cycle, done_o, expDone);
        end
        total++;
        assert (busy_o === expBusy) else begin
            bad++;
            $error("FAIL busy_o cycle=%0d got=%b exp=%b", cycle, busy_o, expBusy);
        end
        total++;
        assert (result_o === expResult) else begin
            bad++;
            $error("FAIL result_o cycle=%0d got=%h exp=%h", cycle, result_o, expResult);
        end
    endtask

    // Checks the current cycle, then moves to just after the next rising edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checkOutput();
            @(posedge clk);
            #1;
        end
    endtask

    // Drives a one-cycle start in the current cycle and records what the DUT must produce.
    task automatic applyStimulus(input logic [1:0] op, input logic [4:0] sh,
                                 input logic [31:0] d, input logic [31:0] expRes);
        expEntry_t e;
        start_i = 1'b1;
        op_i    = op;
        shamt_i = sh;
        data_i  = d;
        e.doneCycle = cycle + int'(sh) + 1;
        e.res       = expRes;
        expQ.push_back(e);
        busyFrom = cycle + 1;
        busyTo   = cycle + int'(sh);
        tick(1);
        start_i = 1'b0;
    endtask

    initial begin
        logic [1:0]  rOp;
        logic [4:0]  rSh;
        logic [31:0] rData;

        rst_n   = 1'b0;
        start_i = 1'b0;
        flush_i = 1'b0;
        op_i    = 2'b00;
        shamt_i = 5'd0;
        data_i  = 32'h0;

        // Reset held for two edges: everything idle and zero.
        @(posedge clk);
        @(posedge clk);
        #1;
        tick(1);
        rst_n = 1'b1;
        tick(1);

        // SLL by 2 of all ones.
        applyStimulus(2'b00, 5'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFC);
        tick(3);

        // Full-width arithmetic and logical right shifts of the sign bit.
        applyStimulus(2'b11, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF);
        tick(32);
        applyStimulus(2'b01, 5'd31, 32'h8000_0000, 32'h0000_0001);
        tick(32);

        // Zero shift completes next cycle without ever raising busy.
        applyStimulus(2'b00, 5'd0, 32'hFFFF_7FFF, 32'hFFFF_7FFF);
        tick(2);

        // Start during SHIFT is ignored; start in the DONE cycle is taken back-to-back.
        applyStimulus(2'b00, 5'd4, 32'h0000_0001, 32'h0000_0010);
        tick(1);
        start_i = 1'b1;
        op_i    = 2'b01;
        shamt_i = 5'd1;
        data_i  = 32'hDEAD_BEEF;
        tick(1);
        start_i = 1'b0;
        tick(2);
        applyStimulus(2'b01, 5'd1, 32'h0000_0004, 32'h0000_0002);
        tick(3);

        // Flush three cycles into a long shift: no done, result keeps its old value.
        applyStimulus(2'b00, 5'd10, 32'h0000_1234, 32'h0048_D000);
        tick(2);
        flush_i = 1'b1;
        expQ.delete();
        busyTo = cycle;
        tick(1);
        flush_i = 1'b0;
        tick(12);

        // Flush wins over a simultaneous start.
        flush_i = 1'b1;
        start_i = 1'b1;
        op_i    = 2'b00;
        shamt_i = 5'd3;
        data_i  = 32'h0000_00FF;
        tick(1);
        flush_i = 1'b0;
        start_i = 1'b0;
        tick(5);

        // A few random operations, including the reserved opcode.
        for (int k = 0; k < 5; k++) begin
            rOp   = 2'($urandom_range(3, 0));
            rSh   = 5'($urandom_range(31, 0));
            rData = $urandom;
            applyStimulus(rOp, rSh, rData, shiftModel(rOp, rSh, rData));
            tick(int'(rSh) + 2);
        end
        applyStimulus(2'b10, 5'd3, 32'h8000_0001, 32'h0000_0008);
        tick(5);

        // Reset three cycles into a long shift: outputs return to zero, no done.
        applyStimulus(2'b01, 5'd10, 32'hF000_0000, 32'h003C_0000);
        tick(2);
        rst_n = 1'b0;
        expQ.delete();
        busyTo = cycle;
        tick(1);
        expResult = 32'h0;
        rst_n = 1'b1;
        tick(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
